// File: rtl/keccak_pkg.sv
// Shared Keccak constants and types used by the squeeze/output stage.
package keccak_pkg;

  localparam int OUT_LEN_WIDTH   = 16;
  localparam int SQZ_CARRY_WIDTH = 248;

  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_512 = 576;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  typedef enum logic [1:0] {
    SQZ_IDLE,
    SQZ_WAIT_STATE,
    SQZ_EMIT
  } keccak_sqz_state;

endpackage

// File: rtl/keccak_byte_window.sv
// Assembles one output word: carry bytes in the low lanes, then snapshot bytes from off.
module keccak_byte_window
  import keccak_pkg::*;
#(
  parameter int DWIDTH          = 256,
  parameter int MAX_RATE        = 1344,
  parameter int SQZ_CARRY_WIDTH = DWIDTH - 8,
  parameter int OFF_W           = 8,
  parameter int CNT_W           = 5
) (
  input  logic [MAX_RATE-1:0]        snapshot,
  input  logic [OFF_W-1:0]           off,
  input  logic [SQZ_CARRY_WIDTH-1:0] carry,
  input  logic [CNT_W-1:0]           carry_cnt,
  output logic [DWIDTH-1:0]          word
);

  logic [DWIDTH-1:0] snap_word;
  logic [DWIDTH-1:0] carry_word;
  logic [DWIDTH-1:0] carry_mask;

  always_comb begin
    // Snapshot bytes past the end of the buffer shift in as zero.
    snap_word  = DWIDTH'(snapshot >> {off, 3'b000}) << {carry_cnt, 3'b000};
    carry_word = DWIDTH'(carry);
    carry_mask = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      carry_mask[i] = ((i / 8) < int'(carry_cnt));
    end
    word = (snap_word & ~carry_mask) | (carry_word & carry_mask);
  end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Squeeze stage: snapshots the rate part of each permuted state and streams the
// requested byte count as packed AXI-Stream words, requesting more permutations as needed.
module keccak_squeeze_unit
  import keccak_pkg::*;
#(
  parameter int DWIDTH          = 256,
  parameter int KEEP_WIDTH      = DWIDTH / 8,
  parameter int MAX_RATE        = 1344,
  parameter int RATE_WIDTH      = 11,
  parameter int OUT_LEN_WIDTH   = keccak_pkg::OUT_LEN_WIDTH,
  parameter int SQZ_CARRY_WIDTH = DWIDTH - 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [RATE_WIDTH-1:0]    rate_i,
  input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
  input  logic [1599:0]            state_i,
  input  logic                     state_valid_i,
  output logic                     perm_req_o,
  output logic [DWIDTH-1:0]        m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep_o,
  output logic                     m_axis_tvalid_o,
  output logic                     m_axis_tlast_o,
  input  logic                     m_axis_tready_i,
  output logic                     busy_o
);

  localparam int RB_W  = RATE_WIDTH - 3;
  localparam int CNT_W = $clog2(KEEP_WIDTH);
  localparam int AV_W  = RB_W + 1;

  keccak_sqz_state fsm_state, fsm_next;

  logic [RB_W-1:0]            rate_b;
  logic [RB_W-1:0]            off;
  logic [CNT_W-1:0]           carry_cnt;
  logic [SQZ_CARRY_WIDTH-1:0] carry;
  logic [OUT_LEN_WIDTH-1:0]   remaining;
  logic [MAX_RATE-1:0]        snapshot;

  logic [DWIDTH-1:0]     word;
  logic [AV_W-1:0]       avail;
  logic                  is_final;
  logic                  is_full;
  logic                  start_ok;
  logic                  capture;
  logic                  handshake;
  logic                  perm_path;
  logic [KEEP_WIDTH-1:0] keep;
  logic                  unused_inputs;

  function automatic logic [KEEP_WIDTH-1:0] byte_mask(input logic [AV_W-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      m[k] = (k < int'(n));
    end
    return m;
  endfunction

  function automatic logic [DWIDTH-1:0] expand_keep(input logic [KEEP_WIDTH-1:0] k);
    logic [DWIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      m[i] = k[i / 8];
    end
    return m;
  endfunction

  assign unused_inputs = ^{state_i[1599:MAX_RATE], rate_i[2:0]};

  keccak_byte_window #(
    .DWIDTH          (DWIDTH),
    .MAX_RATE        (MAX_RATE),
    .SQZ_CARRY_WIDTH (SQZ_CARRY_WIDTH),
    .OFF_W           (RB_W),
    .CNT_W           (CNT_W)
  ) u_window (
    .snapshot  (snapshot),
    .off       (off),
    .carry     (carry),
    .carry_cnt (carry_cnt),
    .word      (word)
  );

  assign start_ok = start_i && (out_len_i != '0);
  assign capture  = state_valid_i &&
                    ((fsm_state == SQZ_WAIT_STATE) || ((fsm_state == SQZ_IDLE) && start_ok));
  assign avail    = AV_W'(carry_cnt) + AV_W'(rate_b) - AV_W'(off);
  assign is_final = (remaining <= OUT_LEN_WIDTH'(KEEP_WIDTH)) &&
                    (remaining <= OUT_LEN_WIDTH'(avail));
  assign is_full  = !is_final && (avail >= AV_W'(KEEP_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= SQZ_IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  always_comb begin
    fsm_next        = fsm_state;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    perm_req_o      = 1'b0;
    keep            = '0;
    unique case (fsm_state)
      SQZ_IDLE: begin
        if (start_ok) fsm_next = state_valid_i ? SQZ_EMIT : SQZ_WAIT_STATE;
      end
      SQZ_WAIT_STATE: begin
        if (state_valid_i) fsm_next = SQZ_EMIT;
      end
      SQZ_EMIT: begin
        if (is_final) begin
          m_axis_tvalid_o = 1'b1;
          m_axis_tlast_o  = 1'b1;
          keep            = byte_mask(AV_W'(remaining));
          if (m_axis_tready_i) fsm_next = SQZ_IDLE;
        end else if (is_full) begin
          m_axis_tvalid_o = 1'b1;
          keep            = '1;
        end else begin
          perm_req_o = 1'b1;
          fsm_next   = SQZ_WAIT_STATE;
        end
      end
      default: fsm_next = SQZ_IDLE;
    endcase
  end

  assign handshake      = m_axis_tvalid_o && m_axis_tready_i;
  assign perm_path      = (fsm_state == SQZ_EMIT) && !is_final && !is_full;
  assign m_axis_tkeep_o = keep;
  assign m_axis_tdata_o = word & expand_keep(keep);
  assign busy_o         = (fsm_state != SQZ_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_b    <= '0;
      off       <= '0;
      carry_cnt <= '0;
      carry     <= '0;
      remaining <= '0;
      snapshot  <= '0;
    end else begin
      if ((fsm_state == SQZ_IDLE) && start_ok) begin
        rate_b    <= rate_i[RATE_WIDTH-1:3];
        remaining <= out_len_i;
        off       <= '0;
        carry_cnt <= '0;
        carry     <= '0;
      end else if (handshake && !is_final) begin
        off       <= off + RB_W'(KEEP_WIDTH) - RB_W'(carry_cnt);
        carry_cnt <= '0;
        remaining <= remaining - OUT_LEN_WIDTH'(KEEP_WIDTH);
      end else if (perm_path) begin
        // Leftover bytes are always fewer than a word here, so they fit the carry.
        carry     <= SQZ_CARRY_WIDTH'(word & expand_keep(byte_mask(avail)));
        carry_cnt <= CNT_W'(avail);
        off       <= '0;
      end
      if (capture) snapshot <= state_i[MAX_RATE-1:0];
    end
  end

endmodule
